// File: rtl/riscv_pkg.sv
// Shared RV32IM constants for the execute stage.
//   Major opcodes, funct3 codes (ALU, branch, M-extension), the M-extension funct7 and the
//   iterative mul/div unit state type.
package riscv_pkg;

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;

  localparam logic [2:0] F3_ADD  = 3'd0;
  localparam logic [2:0] F3_SLL  = 3'd1;
  localparam logic [2:0] F3_SLT  = 3'd2;
  localparam logic [2:0] F3_SLTU = 3'd3;
  localparam logic [2:0] F3_XOR  = 3'd4;
  localparam logic [2:0] F3_SR   = 3'd5;
  localparam logic [2:0] F3_OR   = 3'd6;
  localparam logic [2:0] F3_AND  = 3'd7;

  localparam logic [2:0] F3_BEQ  = 3'd0;
  localparam logic [2:0] F3_BNE  = 3'd1;
  localparam logic [2:0] F3_BLT  = 3'd4;
  localparam logic [2:0] F3_BGE  = 3'd5;
  localparam logic [2:0] F3_BLTU = 3'd6;
  localparam logic [2:0] F3_BGEU = 3'd7;

  localparam logic [2:0] F3_MUL    = 3'd0;
  localparam logic [2:0] F3_MULH   = 3'd1;
  localparam logic [2:0] F3_MULHSU = 3'd2;
  localparam logic [2:0] F3_MULHU  = 3'd3;
  localparam logic [2:0] F3_DIV    = 3'd4;
  localparam logic [2:0] F3_DIVU   = 3'd5;
  localparam logic [2:0] F3_REM    = 3'd6;
  localparam logic [2:0] F3_REMU   = 3'd7;

  localparam logic [6:0] FUNCT7_MULDIV = 7'b0000001;

  typedef enum logic [1:0] {StIdle, StRun, StDone} muldiv_state_t;

endpackage

// File: rtl/ex_muldiv.sv
// Iterative RV32M multiply/divide unit: 32-step radix-2 shift-add multiply and restoring
// divide on operand magnitudes, with the sign applied when the result is read in DONE.
//   clk, rst    clock and synchronous active-low reset
//   start_i     launch an operation (only honoured in IDLE)
//   op_i        funct3 of the M-op
//   a_i, b_i    rs1 / rs2 operands
//   busy_o      iterating (RUN)
//   done_o      result valid this cycle (DONE)
//   result_o    32-bit result, zero outside DONE
module ex_muldiv
  import riscv_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        start_i,
  input  logic [2:0]  op_i,
  input  logic [31:0] a_i,
  input  logic [31:0] b_i,
  output logic        busy_o,
  output logic        done_o,
  output logic [31:0] result_o
);

  muldiv_state_t state_q, state_d;
  logic [63:0] acc_q, acc_d;
  logic [31:0] b_q, b_d;
  logic [4:0]  cnt_q, cnt_d;
  logic [2:0]  op_q, op_d;
  logic        neg_q, neg_d;    // negate product / quotient
  logic        rneg_q, rneg_d;  // negate remainder (follows dividend)

  logic        a_sgn, b_sgn, a_neg, b_neg, div_zero, div_ovf;
  logic [31:0] a_mag, b_mag;
  logic [32:0] mul_sum;
  logic [32:0] div_part;
  logic [33:0] div_diff;
  logic [63:0] prod;
  logic [31:0] quo, rem;

  always_comb begin
    a_sgn = 1'b0;
    b_sgn = 1'b0;
    case (op_i)
      F3_MULH, F3_DIV, F3_REM: begin a_sgn = 1'b1; b_sgn = 1'b1; end
      F3_MULHSU:               a_sgn = 1'b1;
      default:                 ;
    endcase
  end

  assign a_neg    = a_sgn & a_i[31];
  assign b_neg    = b_sgn & b_i[31];
  assign a_mag    = a_neg ? (32'd0 - a_i) : a_i;
  assign b_mag    = b_neg ? (32'd0 - b_i) : b_i;
  assign div_zero = op_i[2] && (b_i == 32'd0);
  // op_i[0] clear selects the signed DIV/REM variants
  assign div_ovf  = op_i[2] && !op_i[0] && (a_i == 32'h8000_0000) && (b_i == 32'hFFFF_FFFF);

  // Multiply: add multiplicand into the upper half when the LSB is set, then shift right.
  assign mul_sum  = {1'b0, acc_q[63:32]} + (acc_q[0] ? {1'b0, b_q} : 33'd0);
  // Divide: partial remainder shifted left with the next dividend bit, trial subtract.
  assign div_part = acc_q[63:31];
  assign div_diff = {1'b0, div_part} - {2'b00, b_q};

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    b_d     = b_q;
    cnt_d   = cnt_q;
    op_d    = op_q;
    neg_d   = neg_q;
    rneg_d  = rneg_q;
    case (state_q)
      StIdle: begin
        if (start_i) begin
          op_d   = op_i;
          b_d    = b_mag;
          cnt_d  = 5'd0;
          neg_d  = a_neg ^ b_neg;
          rneg_d = a_neg;
          // Special divides preload {remainder, quotient} and skip the iteration.
          if (div_zero) begin
            acc_d   = {a_i, 32'hFFFF_FFFF};
            neg_d   = 1'b0;
            rneg_d  = 1'b0;
            state_d = StDone;
          end else if (div_ovf) begin
            acc_d   = {32'd0, 32'h8000_0000};
            neg_d   = 1'b0;
            rneg_d  = 1'b0;
            state_d = StDone;
          end else begin
            acc_d   = {32'd0, a_mag};
            state_d = StRun;
          end
        end
      end
      StRun: begin
        if (op_q[2]) begin
          if (!div_diff[33]) acc_d = {div_diff[31:0], acc_q[30:0], 1'b1};
          else               acc_d = {div_part[31:0], acc_q[30:0], 1'b0};
        end else begin
          acc_d = {mul_sum, acc_q[31:1]};
        end
        cnt_d = cnt_q + 5'd1;
        if (cnt_q == 5'd31) state_d = StDone;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= StIdle;
      acc_q   <= '0;
      b_q     <= '0;
      cnt_q   <= '0;
      op_q    <= '0;
      neg_q   <= 1'b0;
      rneg_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      b_q     <= b_d;
      cnt_q   <= cnt_d;
      op_q    <= op_d;
      neg_q   <= neg_d;
      rneg_q  <= rneg_d;
    end
  end

  assign prod = neg_q  ? (64'd0 - acc_q)         : acc_q;
  assign quo  = neg_q  ? (32'd0 - acc_q[31:0])  : acc_q[31:0];
  assign rem  = rneg_q ? (32'd0 - acc_q[63:32]) : acc_q[63:32];

  always_comb begin
    result_o = '0;
    if (state_q == StDone) begin
      case (op_q)
        F3_MUL:                         result_o = prod[31:0];
        F3_MULH, F3_MULHSU, F3_MULHU:   result_o = prod[63:32];
        F3_DIV, F3_DIVU:                result_o = quo;
        default:                        result_o = rem;
      endcase
    end
  end

  assign busy_o = (state_q == StRun);
  assign done_o = (state_q == StDone);

endmodule

// File: rtl/ex_stage.sv
// RV32IM execute stage: single-cycle ALU, branch unit and output mux, plus the iterative
// mul/div unit that holds the pipeline through stallreq_o while it runs.
//   clk, rst               clock and synchronous active-low reset
//   ex_*                   instruction fields from the ID/EX register
//   wd_o, wreg_o, wdata_o  writeback fields for EX/MEM
//   mem_*_o                load/store fields for the MEM stage
//   branch_flag_o/target   PC redirect
//   stallreq_o             hold PC/IF/ID while an M-op is issuing or running
module ex_stage
  import riscv_pkg::*;
#(
  parameter int unsigned MULDIV_EN = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] ex_pc,
  input  logic [31:0] ex_reg1,
  input  logic [31:0] ex_reg2,
  input  logic [6:0]  ex_opcode,
  input  logic [2:0]  ex_funct,
  input  logic [4:0]  ex_wd,
  input  logic        ex_wreg,
  input  logic [31:0] ex_imm,
  output logic [4:0]  wd_o,
  output logic        wreg_o,
  output logic [31:0] wdata_o,
  output logic [6:0]  mem_opcode_o,
  output logic [2:0]  mem_funct_o,
  output logic [31:0] mem_addr_o,
  output logic [31:0] mem_sdata_o,
  output logic        branch_flag_o,
  output logic [31:0] branch_target_o,
  output logic        stallreq_o
);

  localparam bit MdEn = (MULDIV_EN != 0);

  logic        is_mop, md_start, md_busy, md_done;
  logic [31:0] md_result;
  logic [4:0]  wd_q, wd_d;
  logic        wreg_q, wreg_d;

  assign is_mop   = (ex_opcode == OPC_OP) && (ex_imm[11:5] == FUNCT7_MULDIV);
  assign md_start = MdEn && rst && is_mop && !md_busy && !md_done;

  if (MdEn) begin : g_muldiv
    ex_muldiv u_muldiv (
      .clk      (clk),
      .rst      (rst),
      .start_i  (md_start),
      .op_i     (ex_funct),
      .a_i      (ex_reg1),
      .b_i      (ex_reg2),
      .busy_o   (md_busy),
      .done_o   (md_done),
      .result_o (md_result)
    );
  end else begin : g_no_muldiv
    assign md_busy   = 1'b0;
    assign md_done   = 1'b0;
    assign md_result = '0;
  end

  // Destination of the in-flight M-op; ID/EX carries bubbles by the time it completes.
  assign wd_d   = md_start ? ex_wd   : wd_q;
  assign wreg_d = md_start ? ex_wreg : wreg_q;

  always_ff @(posedge clk) begin
    if (!rst) begin
      wd_q   <= '0;
      wreg_q <= 1'b0;
    end else begin
      wd_q   <= wd_d;
      wreg_q <= wreg_d;
    end
  end

  // ALU. funct7[5] arrives in ex_imm[10] for R-type and shift-immediates.
  logic [31:0]        op_b, alu_res, add_res, srl_res, pc_imm, addr_sum;
  logic signed [31:0] sra_res;
  logic [4:0]         shamt;
  logic               alt, br_eq, br_lt, br_ltu, br_take;

  assign op_b     = (ex_opcode == OPC_OP) ? ex_reg2 : ex_imm;
  assign shamt    = op_b[4:0];
  assign alt      = ex_imm[10];
  assign add_res  = (ex_opcode == OPC_OP && alt) ? (ex_reg1 - op_b) : (ex_reg1 + op_b);
  assign srl_res  = ex_reg1 >> shamt;
  assign sra_res  = $signed(ex_reg1) >>> shamt;
  assign pc_imm   = ex_pc + ex_imm;
  assign addr_sum = ex_reg1 + ex_imm;

  always_comb begin
    case (ex_funct)
      F3_ADD:  alu_res = add_res;
      F3_SLL:  alu_res = ex_reg1 << shamt;
      F3_SLT:  alu_res = {31'd0, $signed(ex_reg1) < $signed(op_b)};
      F3_SLTU: alu_res = {31'd0, ex_reg1 < op_b};
      F3_XOR:  alu_res = ex_reg1 ^ op_b;
      F3_SR:   alu_res = alt ? sra_res : srl_res;
      F3_OR:   alu_res = ex_reg1 | op_b;
      default: alu_res = ex_reg1 & op_b;
    endcase
  end

  assign br_eq  = (ex_reg1 == ex_reg2);
  assign br_lt  = $signed(ex_reg1) < $signed(ex_reg2);
  assign br_ltu = ex_reg1 < ex_reg2;

  always_comb begin
    case (ex_funct)
      F3_BEQ:  br_take = br_eq;
      F3_BNE:  br_take = !br_eq;
      F3_BLT:  br_take = br_lt;
      F3_BGE:  br_take = !br_lt;
      F3_BLTU: br_take = br_ltu;
      F3_BGEU: br_take = !br_ltu;
      default: br_take = 1'b0;
    endcase
  end

  always_comb begin
    wd_o            = '0;
    wreg_o          = 1'b0;
    wdata_o         = '0;
    mem_opcode_o    = '0;
    mem_funct_o     = '0;
    mem_addr_o      = '0;
    mem_sdata_o     = '0;
    branch_flag_o   = 1'b0;
    branch_target_o = '0;
    stallreq_o      = 1'b0;
    if (!rst) begin
      // everything held at zero
    end else if (md_done) begin
      wd_o    = wd_q;
      wreg_o  = wreg_q;
      wdata_o = md_result;
    end else if (md_busy || md_start) begin
      stallreq_o = 1'b1;
    end else if (ex_opcode != 7'd0) begin
      wd_o         = ex_wd;
      mem_opcode_o = ex_opcode;
      mem_funct_o  = ex_funct;
      case (ex_opcode)
        OPC_LUI:   begin wreg_o = ex_wreg; wdata_o = ex_imm; end
        OPC_AUIPC: begin wreg_o = ex_wreg; wdata_o = pc_imm; end
        // M-op with the unit absent writes zero
        OPC_OP:     begin wreg_o = ex_wreg; wdata_o = is_mop ? 32'd0 : alu_res; end
        OPC_OP_IMM: begin wreg_o = ex_wreg; wdata_o = alu_res; end
        OPC_JAL: begin
          wreg_o = ex_wreg; wdata_o = ex_pc + 32'd4;
          branch_flag_o = 1'b1; branch_target_o = pc_imm;
        end
        OPC_JALR: begin
          wreg_o = ex_wreg; wdata_o = ex_pc + 32'd4;
          branch_flag_o = 1'b1; branch_target_o = {addr_sum[31:1], 1'b0};
        end
        OPC_BRANCH: begin branch_flag_o = br_take; branch_target_o = pc_imm; end
        OPC_LOAD:   begin wreg_o = ex_wreg; mem_addr_o = addr_sum; end
        OPC_STORE:  begin mem_addr_o = addr_sum; mem_sdata_o = ex_reg2; end
        default:    ;
      endcase
    end
  end

endmodule
